// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared types and constants for the PS/2 scan-code decoder.
//   kbd_state_t : pop FSM states (IDLE -> POP -> GAP -> IDLE)
//   KBD_EXT     : extended-key prefix byte (0xE0)
//   KBD_BRK     : break (key release) prefix byte (0xF0)
// -----------------------------------------------------------------------------
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } kbd_state_t;

  localparam logic [7:0] KBD_EXT = 8'hE0;
  localparam logic [7:0] KBD_BRK = 8'hF0;

endpackage

// File: rtl/kbd_ascii_rom.sv
// -----------------------------------------------------------------------------
// kbd_ascii_rom
// Scan-code set 2 to ASCII lookup. Only lowercase letters, digits 0-9, space
// and enter are mapped; everything else, and any E0-prefixed code, gives 0x00.
// Purely combinational.
// Ports:
//   i_code  [7:0] : scan code (without prefixes)
//   i_ext         : code was E0-prefixed
//   o_ascii [7:0] : ASCII character or 0x00
// Only instantiated when KBD_ASCII_EN is defined.
// -----------------------------------------------------------------------------
module kbd_ascii_rom (
  input  logic [7:0] i_code,
  input  logic       i_ext,
  output logic [7:0] o_ascii
);

  logic [7:0] w_base;

  always_comb begin
    w_base = 8'h00;
    case (i_code)
      8'h1C: w_base = 8'h61; // a
      8'h32: w_base = 8'h62; // b
      8'h21: w_base = 8'h63; // c
      8'h23: w_base = 8'h64; // d
      8'h24: w_base = 8'h65; // e
      8'h2B: w_base = 8'h66; // f
      8'h34: w_base = 8'h67; // g
      8'h33: w_base = 8'h68; // h
      8'h43: w_base = 8'h69; // i
      8'h3B: w_base = 8'h6A; // j
      8'h42: w_base = 8'h6B; // k
      8'h4B: w_base = 8'h6C; // l
      8'h3A: w_base = 8'h6D; // m
      8'h31: w_base = 8'h6E; // n
      8'h44: w_base = 8'h6F; // o
      8'h4D: w_base = 8'h70; // p
      8'h15: w_base = 8'h71; // q
      8'h2D: w_base = 8'h72; // r
      8'h1B: w_base = 8'h73; // s
      8'h2C: w_base = 8'h74; // t
      8'h3C: w_base = 8'h75; // u
      8'h2A: w_base = 8'h76; // v
      8'h1D: w_base = 8'h77; // w
      8'h22: w_base = 8'h78; // x
      8'h35: w_base = 8'h79; // y
      8'h1A: w_base = 8'h7A; // z
      8'h45: w_base = 8'h30; // 0
      8'h16: w_base = 8'h31; // 1
      8'h1E: w_base = 8'h32; // 2
      8'h26: w_base = 8'h33; // 3
      8'h25: w_base = 8'h34; // 4
      8'h2E: w_base = 8'h35; // 5
      8'h36: w_base = 8'h36; // 6
      8'h3D: w_base = 8'h37; // 7
      8'h3E: w_base = 8'h38; // 8
      8'h46: w_base = 8'h39; // 9
      8'h29: w_base = 8'h20; // space
      8'h5A: w_base = 8'h0D; // enter
      default: w_base = 8'h00;
    endcase
  end

  // Extended codes (keypad enter, arrows, ...) deliberately report nothing.
  assign o_ascii = i_ext ? 8'h00 : w_base;

endmodule

// File: rtl/kbd_scan_decoder.sv
// -----------------------------------------------------------------------------
// kbd_scan_decoder
// Pops scan-code bytes from the ps2_keyboard FIFO and turns the E0/F0 prefixed
// byte stream into make/break key events with a held-key tracker, a press
// counter and a sticky overflow flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | wait for kb_ready; byte is captured on the leaving edge
// POP   | kb_nextdata_n low for one cycle; captured byte is decoded
// GAP   | one dead cycle so the FIFO can present its next byte
//
// Ports:
//   clk, rst (sync, active-high)
//   kb_data[7:0], kb_ready, kb_overflow : from ps2_keyboard
//   kb_nextdata_n                        : active-low pop strobe
//   key_valid                            : one-cycle event pulse
//   key_code[7:0], key_extended          : last reported code
//   key_pressed                          : a key is currently held
//   key_ascii[7:0]                       : ASCII of key_code (0x00 if none)
//   press_count[COUNT_W-1:0]             : wrapping count of new makes
//   ovf_flag                             : sticky upstream overflow
// Configuration: define KBD_ASCII_EN to enable the ASCII lookup; otherwise
// key_ascii is tied to 0x00.
// -----------------------------------------------------------------------------
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         kb_data,
  input  logic               kb_ready,
  input  logic               kb_overflow,
  output logic               kb_nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_extended,
  output logic               key_pressed,
  output logic [7:0]         key_ascii,
  output logic [COUNT_W-1:0] press_count,
  output logic               ovf_flag
);

  kbd_state_t r_state;
  kbd_state_t w_state_nxt;
  logic       w_capture;
  logic       w_pop;

  logic [7:0] r_byte;
  logic       r_ext_pfx;
  logic       r_brk_pfx;

  logic               r_key_valid;
  logic [7:0]         r_key_code;
  logic               r_key_extended;
  logic               r_key_pressed;
  logic [COUNT_W-1:0] r_press_count;
  logic               r_ovf_flag;

  logic w_is_ext;
  logic w_is_brk;
  logic w_is_code;
  logic w_match_held;
  logic w_make_new;
  logic w_break;

  // ---------------------------------------------------------------------------
  // Pop FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (kb_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        w_pop       = 1'b1;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        // kb_ready may still reflect the byte just popped; ignore it here.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign kb_nextdata_n = ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte <= 8'h00;
    end else if (w_capture) begin
      r_byte <= kb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte decode (evaluated during POP)
  // ---------------------------------------------------------------------------
  assign w_is_ext  = w_pop && (r_byte == KBD_EXT);
  assign w_is_brk  = w_pop && (r_byte == KBD_BRK);
  assign w_is_code = w_pop && (r_byte != KBD_EXT) && (r_byte != KBD_BRK);

  // The held key is identified by code plus extended flag, and only while a
  // key is actually held; after a release the same code counts as a new make.
  assign w_match_held = r_key_pressed &&
                        (r_key_code == r_byte) &&
                        (r_key_extended == r_ext_pfx);

  // A make that matches the held key is typematic repeat and is swallowed.
  assign w_make_new = w_is_code && !r_brk_pfx && !w_match_held;
  assign w_break    = w_is_code &&  r_brk_pfx;

  // Overflow wins over any prefix update in the same cycle; a code byte
  // decoded in that cycle still used the flags as they were captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_pfx <= 1'b0;
      r_brk_pfx <= 1'b0;
    end else if (kb_overflow) begin
      r_ext_pfx <= 1'b0;
      r_brk_pfx <= 1'b0;
    end else if (w_is_ext) begin
      r_ext_pfx <= 1'b1;
    end else if (w_is_brk) begin
      r_brk_pfx <= 1'b1;
    end else if (w_is_code) begin
      r_ext_pfx <= 1'b0;
      r_brk_pfx <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Key event registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_valid    <= 1'b0;
      r_key_code     <= 8'h00;
      r_key_extended <= 1'b0;
      r_key_pressed  <= 1'b0;
      r_press_count  <= '0;
    end else begin
      r_key_valid <= w_make_new || w_break;
      if (w_make_new || w_break) begin
        r_key_code     <= r_byte;
        r_key_extended <= r_ext_pfx;
      end
      if (w_make_new) begin
        r_key_pressed <= 1'b1;
        r_press_count <= r_press_count + COUNT_W'(1);
      end else if (w_break && w_match_held) begin
        // Releasing some other key leaves the held key alone.
        r_key_pressed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_flag <= 1'b0;
    end else if (kb_overflow) begin
      r_ovf_flag <= 1'b1;
    end
  end

  assign key_valid    = r_key_valid;
  assign key_code     = r_key_code;
  assign key_extended = r_key_extended;
  assign key_pressed  = r_key_pressed;
  assign press_count  = r_press_count;
  assign ovf_flag     = r_ovf_flag;

  // ---------------------------------------------------------------------------
  // ASCII translation
  // ---------------------------------------------------------------------------
`ifdef KBD_ASCII_EN
  kbd_ascii_rom u_ascii_rom (
    .i_code  (r_key_code),
    .i_ext   (r_key_extended),
    .o_ascii (key_ascii)
  );
`else
  assign key_ascii = 8'h00;
`endif

endmodule
